smvm_row_collector: RTL and testbench
=====================================

Name: smvm_row_collector

Overview:
- Output stage directly downstream of the SMVM datapath.
- Takes the signed row partial sums from the two accumulator lanes (left/right) and adds them into a per-row result buffer.
- Once the matrix stream is finished, emits the result vector in row order, one saturated 14-bit value per cycle, on out_valid/data_out.

Parameters:
- MAX_ROWS, 128, depth of the row result buffer (matches the 128-entry vector store).
- ROW_W, 7, row index width, equal to clog2(MAX_ROWS).
- ACC_W, 28, partial-sum and accumulator width, two's complement.
- OUT_W, 14, output width, two's complement.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous reset, active-high.
- start  in  1  one-cycle pulse that opens a new matrix; honoured only in IDLE.
- num_rows  in  8  row count, sampled on start; legal range 0..MAX_ROWS.
- l_valid  in  1  left-lane partial sum valid.
- l_row  in  ROW_W  left-lane target row.
- l_sum  in  ACC_W  left-lane partial sum, signed.
- r_valid  in  1  right-lane partial sum valid.
- r_row  in  ROW_W  right-lane target row.
- r_sum  in  ACC_W  right-lane partial sum, signed.
- flush  in  1  last partial of the matrix is on the lanes this cycle or earlier.
- busy  out  1  high in ACCUM and DRAIN.
- out_valid  out  1  data_out carries a result row.
- data_out  out  OUT_W  saturated row result.
- done  out  1  one-cycle pulse marking the end of the result vector.
- err  out  1  sticky error flag; cleared by rst or start.

Behaviour:
- Reset (rst high at a clock edge):
  - state returns to IDLE.
  - All accumulators, the row counter and the stored num_rows are zeroed.
  - busy, out_valid, done and err all read 0; data_out reads 0.
  - rst has priority over every other input, including in the middle of ACCUM or DRAIN.
- States are IDLE, ACCUM and DRAIN.
- IDLE:
  - On start, capture num_rows, zero all MAX_ROWS accumulators in the same edge, clear err, and go to ACCUM.
  - Lane valids are ignored in IDLE.
- ACCUM:
  - Each valid lane updates its row: acc[row] <= acc[row] + sum, wrapping modulo 2^ACC_W.
  - If both lanes are valid and l_row == r_row, that row is updated once: acc[row] + l_sum + r_sum, wrapping.
  - A lane with row >= the captured num_rows is dropped and sets err.
  - A start pulse in ACCUM is ignored.
- flush:
  - When flush is sampled high in cycle t during ACCUM, the lane updates of cycle t are still applied.
  - The state then becomes DRAIN with the row counter at 0.
- DRAIN:
  - out_valid is high in cycles t+1 .. t+num_rows.
  - data_out in cycle t+k is sat(acc[k-1]), so rows are emitted in ascending order with no gaps.
  - Rows that never received a partial emit 0.
  - done pulses together with the last out_valid, then the state returns to IDLE.
  - Lane valids seen during DRAIN are dropped and set err.
  - start and flush in DRAIN are ignored.
- num_rows == 0: flush in cycle t gives no out_valid; done pulses alone in cycle t+1, then IDLE.
- num_rows > MAX_ROWS: clamp to MAX_ROWS and set err at the start edge.
- Saturation (sat):
  - value > 2^(OUT_W-1)-1 gives 8191.
  - value < -2^(OUT_W-1) gives -8192.
  - Otherwise the value passes through truncated.
- Registered outputs: out_valid, data_out and done come straight from flops, so no combinational path runs from any input to any output.
- busy is high from the edge after start until the edge after done.

Decomposition:
- Shared package smvm_pkg holds:
  - ROW_W, ACC_W and OUT_W.
  - The state encoding for IDLE, ACCUM and DRAIN.
  - The function sat_out(ACC_W value) returning an OUT_W value.
- One natural sub-module, smvm_sat, which is the combinational ACC_W-to-OUT_W clamp. It is instantiated once on the drain read path.
- The dual-lane accumulate-with-merge logic stays in the top.

Test Plan:
1. Basic accumulate and drain:
   - start with num_rows=3.
   - Left lane: (row0, +5). Right lane: (row2, -7).
   - Next cycle, left lane (row0, +10) together with flush.
   - Expect out_valid for exactly 3 cycles with data_out = 15, 0, -7, done on the third cycle, and err=0.
2. Same-row merge:
   - num_rows=1.
   - One cycle with l=(row0, 100) and r=(row0, 23).
   - Expect data_out = 123 on a single output cycle.
3. Saturation:
   - num_rows=2.
   - Row0 gets +9000. Row1 gets -20000 split as -10000 on each lane.
   - Expect output 8191, then -8192.
4. Out-of-range and misuse:
   - num_rows=4.
   - Send a partial to row 5: err goes to 1, the partial is dropped and all outputs are 0.
   - Send start during ACCUM: no effect.
   - A new start in IDLE clears err.
5. Zero rows and mid-operation reset:
   - num_rows=0 with flush: done one cycle later and no out_valid.
   - Separately, assert rst on the second DRAIN cycle of a 4-row matrix.
   - Expect out_valid=0 on the next cycle, busy=0, and the next matrix starting from cleared accumulators.
6. Back-to-back matrices:
   - start in the cycle right after done.
   - Expect acceptance and full clearing, with the second result vector independent of the first.

Source files
------------

// File: rtl/smvm_pkg.sv
// Shared definitions for the SMVM row collector: widths, state encoding and
// the output saturation helper.
package smvm_pkg;

  localparam int MAX_ROWS = 128;
  localparam int ROW_W    = 7;
  localparam int ACC_W    = 28;
  localparam int OUT_W    = 14;

  localparam int SAT_MAX_I = (1 << (OUT_W - 1)) - 1;
  localparam int SAT_MIN_I = -(1 << (OUT_W - 1));

  localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'(SAT_MAX_I);
  localparam logic signed [ACC_W-1:0] SAT_MIN = ACC_W'(SAT_MIN_I);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  // Clamp a wide accumulator value into the signed output range.
  function automatic logic signed [OUT_W-1:0] sat_out(input logic signed [ACC_W-1:0] value);
    logic signed [OUT_W-1:0] result;
    if (value > SAT_MAX) begin
      result = {1'b0, {(OUT_W-1){1'b1}}};
    end else if (value < SAT_MIN) begin
      result = {1'b1, {(OUT_W-1){1'b0}}};
    end else begin
      result = value[OUT_W-1:0];
    end
    return result;
  endfunction

endpackage

// File: rtl/smvm_sat.sv
// Combinational ACC_W-to-OUT_W clamp used on the drain read path.
module smvm_sat
  import smvm_pkg::*;
(
  input  logic signed [ACC_W-1:0] value,
  output logic signed [OUT_W-1:0] result
);

  // Saturate the selected accumulator into the output range.
  always_comb begin
    result = sat_out(value);
  end

endmodule

// File: rtl/smvm_row_collector.sv
// Row result collector: merges left/right lane partial sums into a per-row
// accumulator buffer and streams the saturated result vector once flushed.
module smvm_row_collector
  import smvm_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [7:0]              num_rows,
  input  logic                    l_valid,
  input  logic [ROW_W-1:0]        l_row,
  input  logic signed [ACC_W-1:0] l_sum,
  input  logic                    r_valid,
  input  logic [ROW_W-1:0]        r_row,
  input  logic signed [ACC_W-1:0] r_sum,
  input  logic                    flush,
  output logic                    busy,
  output logic                    out_valid,
  output logic signed [OUT_W-1:0] data_out,
  output logic                    done,
  output logic                    err
);

  state_t                  state;
  logic signed [ACC_W-1:0] acc [MAX_ROWS];
  logic [7:0]              rows_q;
  // Index of the next row to emit; row 0 goes out on the flush edge itself,
  // so on entering DRAIN this already points at row 1.
  logic [7:0]              rd_idx;

  logic                    l_in;
  logic                    r_in;
  logic signed [ACC_W-1:0] l_add0;
  logic signed [ACC_W-1:0] r_add0;
  logic signed [ACC_W-1:0] row0_next;
  logic signed [ACC_W-1:0] sat_in;
  logic signed [OUT_W-1:0] sat_val;

  // Lane range checks, the row-0 value including this cycle's partials (needed
  // when row 0 is emitted on the flush edge), and the drain read mux.
  always_comb begin
    l_in      = ({1'b0, l_row} < rows_q);
    r_in      = ({1'b0, r_row} < rows_q);
    l_add0    = (l_valid && l_in && (l_row == '0)) ? l_sum : '0;
    r_add0    = (r_valid && r_in && (r_row == '0)) ? r_sum : '0;
    row0_next = acc[0] + l_add0 + r_add0;
    sat_in    = (state == ST_ACCUM) ? row0_next : acc[rd_idx[ROW_W-1:0]];
  end

  smvm_sat u_sat (
    .value  (sat_in),
    .result (sat_val)
  );

  // Main controller: accumulate in ACCUM, stream rows in DRAIN, registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      for (int i = 0; i < MAX_ROWS; i++) acc[i] <= '0;
      rows_q    <= '0;
      rd_idx    <= '0;
      busy      <= 1'b0;
      out_valid <= 1'b0;
      data_out  <= '0;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          out_valid <= 1'b0;
          done      <= 1'b0;
          data_out  <= '0;
          if (start) begin
            for (int i = 0; i < MAX_ROWS; i++) acc[i] <= '0;
            if (num_rows > 8'(MAX_ROWS)) begin
              rows_q <= 8'(MAX_ROWS);
              err    <= 1'b1;
            end else begin
              rows_q <= num_rows;
              err    <= 1'b0;
            end
            rd_idx <= '0;
            busy   <= 1'b1;
            state  <= ST_ACCUM;
          end
        end

        ST_ACCUM: begin
          if (l_valid && l_in && r_valid && r_in && (l_row == r_row)) begin
            acc[l_row] <= acc[l_row] + l_sum + r_sum;
          end else begin
            if (l_valid && l_in) acc[l_row] <= acc[l_row] + l_sum;
            if (r_valid && r_in) acc[r_row] <= acc[r_row] + r_sum;
          end
          if ((l_valid && !l_in) || (r_valid && !r_in)) err <= 1'b1;
          if (flush) begin
            state <= ST_DRAIN;
            if (rows_q == 8'd0) begin
              out_valid <= 1'b0;
              data_out  <= '0;
              done      <= 1'b1;
              rd_idx    <= '0;
            end else begin
              out_valid <= 1'b1;
              data_out  <= sat_val;
              done      <= (rows_q == 8'd1);
              rd_idx    <= 8'd1;
            end
          end
        end

        ST_DRAIN: begin
          if (l_valid || r_valid) err <= 1'b1;
          if (done) begin
            state     <= ST_IDLE;
            busy      <= 1'b0;
            done      <= 1'b0;
            out_valid <= 1'b0;
            data_out  <= '0;
          end else begin
            out_valid <= 1'b1;
            data_out  <= sat_val;
            done      <= (rd_idx == rows_q - 8'd1);
            rd_idx    <= rd_idx + 8'd1;
          end
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_smvm_row_collector.sv
// Self-checking bench for smvm_row_collector: a reference model fills an
// expected-output queue at flush time and a monitor pops it on every out_valid.
module tb_smvm_row_collector;

  logic               clk;
  logic               rst;
  logic               start;
  logic [7:0]         num_rows;
  logic               l_valid;
  logic [6:0]         l_row;
  logic signed [27:0] l_sum;
  logic               r_valid;
  logic [6:0]         r_row;
  logic signed [27:0] r_sum;
  logic               flush;
  logic               busy;
  logic               out_valid;
  logic signed [13:0] data_out;
  logic               done;
  logic               err;

  typedef struct {
    logic signed [13:0] val;
    bit                 last;
  } exp_t;

  exp_t               sbq[$];
  exp_t               mon_e;
  logic signed [27:0] m_acc [128];
  int                 m_rows;
  int                 checks;
  int                 passes;

  smvm_row_collector dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .num_rows  (num_rows),
    .l_valid   (l_valid),
    .l_row     (l_row),
    .l_sum     (l_sum),
    .r_valid   (r_valid),
    .r_row     (r_row),
    .r_sum     (r_sum),
    .flush     (flush),
    .busy      (busy),
    .out_valid (out_valid),
    .data_out  (data_out),
    .done      (done),
    .err       (err)
  );

  // Free-running clock, 10 time units per cycle.
  always #5 clk = ~clk;

  // Global time limit so the run always terminates.
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  // Scoreboard monitor: every output row is compared against the queue head.
  always @(negedge clk) begin
    if (out_valid === 1'b1) begin
      if (sbq.size() == 0) begin
        checks++;
        $display("[TB] FAIL unexpected_output: data_out=%0d with no expected row", data_out);
      end else begin
        mon_e = sbq.pop_front();
        checks++;
        if (data_out !== mon_e.val)
          $display("[TB] FAIL row_data: got %0d want %0d", data_out, mon_e.val);
        else passes++;
        checks++;
        if (done !== mon_e.last)
          $display("[TB] FAIL row_done: got %b want %b", done, mon_e.last);
        else passes++;
      end
    end
  end

  function automatic logic signed [13:0] model_sat(input logic signed [27:0] v);
    if (v > 28'sd8191) return 14'sd8191;
    if (v < -28'sd8192) return -14'sd8192;
    return v[13:0];
  endfunction

  task automatic start_matrix(input int n);
    num_rows = n[7:0];
    start    = 1'b1;
    @(posedge clk); #1;
    start    = 1'b0;
    m_rows   = (n > 128) ? 128 : n;
    for (int i = 0; i < 128; i++) m_acc[i] = '0;
  endtask

  task automatic drive(input bit lv, input int lrow, input int lsum,
                       input bit rv, input int rrow, input int rsum, input bit fl);
    logic signed [27:0] ls;
    logic signed [27:0] rs;
    ls      = lsum[27:0];
    rs      = rsum[27:0];
    l_valid = lv;
    l_row   = lrow[6:0];
    l_sum   = ls;
    r_valid = rv;
    r_row   = rrow[6:0];
    r_sum   = rs;
    flush   = fl;
    if (lv && lrow < m_rows) m_acc[lrow] = m_acc[lrow] + ls;
    if (rv && rrow < m_rows) m_acc[rrow] = m_acc[rrow] + rs;
    if (fl) begin
      for (int k = 0; k < m_rows; k++) sbq.push_back('{model_sat(m_acc[k]), (k == m_rows - 1)});
    end
    @(posedge clk); #1;
    l_valid = 1'b0;
    r_valid = 1'b0;
    l_sum   = '0;
    r_sum   = '0;
    flush   = 1'b0;
  endtask

  task automatic wait_done(input int budget, output bit seen);
    seen = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        seen = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++; if (busy !== 1'b0) $display("[TB] FAIL reset_busy: got %b want 0", busy); else passes++;
    checks++; if (out_valid !== 1'b0) $display("[TB] FAIL reset_out_valid: got %b want 0", out_valid); else passes++;
    checks++; if (done !== 1'b0) $display("[TB] FAIL reset_done: got %b want 0", done); else passes++;
    checks++; if (err !== 1'b0) $display("[TB] FAIL reset_err: got %b want 0", err); else passes++;
    checks++; if (data_out !== 14'sd0) $display("[TB] FAIL reset_data_out: got %0d want 0", data_out); else passes++;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_basic();
    bit seen;
    $display("[TB] basic accumulate and drain");
    start_matrix(3);
    checks++; if (busy !== 1'b1) $display("[TB] FAIL basic_busy_after_start: got %b want 1", busy); else passes++;
    drive(1, 0, 5, 1, 2, -7, 0);
    drive(1, 0, 10, 0, 0, 0, 1);
    wait_done(10, seen);
    checks++; if (!seen) $display("[TB] FAIL basic_done_timeout: got no done want done"); else passes++;
    @(posedge clk); #1;
    checks++; if (sbq.size() != 0) $display("[TB] FAIL basic_rows_left: got %0d want 0", sbq.size()); else passes++;
    checks++; if (err !== 1'b0) $display("[TB] FAIL basic_err: got %b want 0", err); else passes++;
    checks++; if (busy !== 1'b0) $display("[TB] FAIL basic_busy_after_done: got %b want 0", busy); else passes++;
  endtask

  task automatic test_merge();
    bit seen;
    $display("[TB] same-row merge");
    start_matrix(1);
    drive(1, 0, 100, 1, 0, 23, 1);
    wait_done(10, seen);
    checks++; if (!seen) $display("[TB] FAIL merge_done_timeout: got no done want done"); else passes++;
    @(posedge clk); #1;
    checks++; if (sbq.size() != 0) $display("[TB] FAIL merge_rows_left: got %0d want 0", sbq.size()); else passes++;
  endtask

  task automatic test_saturation();
    bit seen;
    $display("[TB] saturation");
    start_matrix(2);
    drive(1, 0, 9000, 0, 0, 0, 0);
    drive(1, 1, -10000, 1, 1, -10000, 1);
    wait_done(10, seen);
    checks++; if (!seen) $display("[TB] FAIL sat_done_timeout: got no done want done"); else passes++;
    @(posedge clk); #1;
    checks++; if (sbq.size() != 0) $display("[TB] FAIL sat_rows_left: got %0d want 0", sbq.size()); else passes++;
  endtask

  task automatic test_misuse();
    bit seen;
    $display("[TB] out-of-range lane and start during ACCUM");
    start_matrix(4);
    drive(1, 5, 50, 0, 0, 0, 0);
    checks++; if (err !== 1'b1) $display("[TB] FAIL oor_err: got %b want 1", err); else passes++;
    checks++; if (out_valid !== 1'b0) $display("[TB] FAIL oor_out_valid: got %b want 0", out_valid); else passes++;
    checks++; if (done !== 1'b0) $display("[TB] FAIL oor_done: got %b want 0", done); else passes++;
    checks++; if (data_out !== 14'sd0) $display("[TB] FAIL oor_data_out: got %0d want 0", data_out); else passes++;
    num_rows = 8'd1;
    start    = 1'b1;
    @(posedge clk); #1;
    start    = 1'b0;
    checks++; if (busy !== 1'b1) $display("[TB] FAIL accum_start_busy: got %b want 1", busy); else passes++;
    drive(0, 0, 0, 1, 1, 7, 1);
    wait_done(10, seen);
    checks++; if (!seen) $display("[TB] FAIL misuse_done_timeout: got no done want done"); else passes++;
    @(posedge clk); #1;
    checks++; if (sbq.size() != 0) $display("[TB] FAIL misuse_rows_left: got %0d want 0", sbq.size()); else passes++;
    checks++; if (err !== 1'b1) $display("[TB] FAIL err_sticky: got %b want 1", err); else passes++;
    start_matrix(2);
    checks++; if (err !== 1'b0) $display("[TB] FAIL err_clear_on_start: got %b want 0", err); else passes++;
    drive(0, 0, 0, 0, 0, 0, 1);
    wait_done(10, seen);
    checks++; if (!seen) $display("[TB] FAIL misuse2_done_timeout: got no done want done"); else passes++;
    @(posedge clk); #1;
  endtask

  task automatic test_clamp();
    bit seen;
    $display("[TB] num_rows clamp");
    start_matrix(200);
    checks++; if (err !== 1'b1) $display("[TB] FAIL clamp_err: got %b want 1", err); else passes++;
    drive(1, 127, 3, 1, 0, -1, 1);
    wait_done(140, seen);
    checks++; if (!seen) $display("[TB] FAIL clamp_done_timeout: got no done want done"); else passes++;
    @(posedge clk); #1;
    checks++; if (sbq.size() != 0) $display("[TB] FAIL clamp_rows_left: got %0d want 0", sbq.size()); else passes++;
  endtask

  task automatic test_zero_rows();
    $display("[TB] zero rows");
    start_matrix(0);
    drive(0, 0, 0, 0, 0, 0, 1);
    checks++; if (done !== 1'b1) $display("[TB] FAIL zero_done: got %b want 1", done); else passes++;
    checks++; if (out_valid !== 1'b0) $display("[TB] FAIL zero_out_valid: got %b want 0", out_valid); else passes++;
    @(posedge clk); #1;
    checks++; if (done !== 1'b0) $display("[TB] FAIL zero_done_pulse: got %b want 0", done); else passes++;
    checks++; if (busy !== 1'b0) $display("[TB] FAIL zero_busy: got %b want 0", busy); else passes++;
  endtask

  task automatic test_mid_reset();
    bit seen;
    $display("[TB] reset during DRAIN");
    start_matrix(4);
    drive(1, 0, 11, 1, 3, 33, 0);
    drive(0, 0, 0, 0, 0, 0, 1);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    checks++; if (out_valid !== 1'b0) $display("[TB] FAIL midrst_out_valid: got %b want 0", out_valid); else passes++;
    checks++; if (busy !== 1'b0) $display("[TB] FAIL midrst_busy: got %b want 0", busy); else passes++;
    checks++; if (sbq.size() != 2) $display("[TB] FAIL midrst_rows_emitted: got %0d left want 2", sbq.size()); else passes++;
    sbq.delete();
    start_matrix(2);
    drive(0, 0, 0, 0, 0, 0, 1);
    wait_done(10, seen);
    checks++; if (!seen) $display("[TB] FAIL midrst_done_timeout: got no done want done"); else passes++;
    @(posedge clk); #1;
    checks++; if (sbq.size() != 0) $display("[TB] FAIL midrst_rows_left: got %0d want 0", sbq.size()); else passes++;
  endtask

  task automatic test_back_to_back();
    bit seen;
    $display("[TB] back-to-back matrices");
    start_matrix(2);
    drive(1, 0, 1000, 1, 1, 2000, 1);
    wait_done(10, seen);
    checks++; if (!seen) $display("[TB] FAIL b2b_first_done_timeout: got no done want done"); else passes++;
    @(posedge clk); #1;
    start_matrix(3);
    checks++; if (busy !== 1'b1) $display("[TB] FAIL b2b_start_accepted: got %b want 1", busy); else passes++;
    drive(0, 0, 0, 1, 2, 5, 1);
    wait_done(10, seen);
    checks++; if (!seen) $display("[TB] FAIL b2b_second_done_timeout: got no done want done"); else passes++;
    @(posedge clk); #1;
    checks++; if (sbq.size() != 0) $display("[TB] FAIL b2b_rows_left: got %0d want 0", sbq.size()); else passes++;
  endtask

  // Test sequence.
  initial begin
    clk      = 1'b0;
    rst      = 1'b1;
    start    = 1'b0;
    num_rows = '0;
    l_valid  = 1'b0;
    l_row    = '0;
    l_sum    = '0;
    r_valid  = 1'b0;
    r_row    = '0;
    r_sum    = '0;
    flush    = 1'b0;
    checks   = 0;
    passes   = 0;
    m_rows   = 0;
    for (int i = 0; i < 128; i++) m_acc[i] = '0;

    test_reset();
    test_basic();
    test_merge();
    test_saturation();
    test_misuse();
    test_clamp();
    test_zero_rows();
    test_mid_reset();
    test_back_to_back();

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
